// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry show-ahead FIFO of {instr, PC, PC+4}
// with valid/ready toward fetch, stall/flush from decode, and an ISA-specific bubble NOP.
module decode_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            ValidF,
  input  logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  output logic            ReadyF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [CW-1:0]   CountQ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 3 * XLEN;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);
  localparam logic [XLEN-1:0] NOP_ARM = XLEN'(32'hE1A00000);
  localparam logic [XLEN-1:0] NOP_RV = XLEN'(32'h00000013);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, valid;
  logic [EW-1:0] head;

  assign valid  = (count_q != '0);
  assign pop    = valid & ~StallD & ~FlushD;
  assign ReadyF = (count_q < DEPTH_C) | pop;
  assign push   = ValidF & ReadyF & ~FlushD;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (FlushD) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {InstrF, PCF, PCPlus4F};
  end

  always_comb begin
    ValidD   = valid;
    CountQ   = count_q;
    InstrD   = arm ? NOP_ARM : NOP_RV;
    PCD      = '0;
    PCPlus4D = '0;
    if (valid) begin
      InstrD   = head[EW-1 -: XLEN];
      PCD      = head[2*XLEN-1 -: XLEN];
      PCPlus4D = head[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue: DEPTH=4 instance for the main
// scenarios and a DEPTH=3 instance for the pointer-wrap stream.
module tb_decode_queue;

  logic clk = 1'b0;
  logic rst, arm;
  always #5 clk = ~clk;

  logic        ValidF_a, StallD_a, FlushD_a, ReadyF_a, ValidD_a;
  logic [31:0] InstrF_a, PCF_a, PCPlus4F_a, InstrD_a, PCD_a, PCPlus4D_a;
  logic [2:0]  CountQ_a;

  logic        ValidF_b, StallD_b, FlushD_b, ReadyF_b, ValidD_b;
  logic [31:0] InstrF_b, PCF_b, PCPlus4F_b, InstrD_b, PCD_b, PCPlus4D_b;
  logic [1:0]  CountQ_b;

  decode_queue #(.XLEN(32), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .arm(arm),
    .ValidF(ValidF_a), .InstrF(InstrF_a), .PCF(PCF_a), .PCPlus4F(PCPlus4F_a),
    .ReadyF(ReadyF_a), .StallD(StallD_a), .FlushD(FlushD_a),
    .InstrD(InstrD_a), .PCD(PCD_a), .PCPlus4D(PCPlus4D_a),
    .ValidD(ValidD_a), .CountQ(CountQ_a)
  );

  decode_queue #(.XLEN(32), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .arm(arm),
    .ValidF(ValidF_b), .InstrF(InstrF_b), .PCF(PCF_b), .PCPlus4F(PCPlus4F_b),
    .ReadyF(ReadyF_b), .StallD(StallD_b), .FlushD(FlushD_b),
    .InstrD(InstrD_b), .PCD(PCD_b), .PCPlus4D(PCPlus4D_b),
    .ValidD(ValidD_b), .CountQ(CountQ_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    ValidF_a   = v;
    InstrF_a   = ins;
    PCF_a      = pc;
    PCPlus4F_a = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    StallD_a = 1'b0; FlushD_a = 1'b0;
    ValidF_b = 1'b0; InstrF_b = '0; PCF_b = '0; PCPlus4F_b = '0;
    StallD_b = 1'b0; FlushD_b = 1'b0;

    // 1: reset state and bubble encoding
    #2;
    check("rst_validd", {31'd0, ValidD_a}, 32'd0);
    check("rst_instrd_rv", InstrD_a, 32'h00000013);
    check("rst_readyf", {31'd0, ReadyF_a}, 32'd1);
    check("rst_countq", {29'd0, CountQ_a}, 32'd0);
    check("rst_pcd", PCD_a, 32'd0);
    check("rst_pcplus4d", PCPlus4D_a, 32'd0);
    arm = 1'b1;
    #1;
    check("rst_instrd_arm", InstrD_a, 32'hE1A00000);
    rst = 1'b1; arm = 1'b0;

    // 2: single push, visible the next cycle, then drains
    drive_a(1'b1, 32'h00500093, 32'h100);
    #1;
    check("push_validd_same_cycle", {31'd0, ValidD_a}, 32'd0);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    check("push_validd", {31'd0, ValidD_a}, 32'd1);
    check("push_instrd", InstrD_a, 32'h00500093);
    check("push_pcd", PCD_a, 32'h100);
    check("push_pcplus4d", PCPlus4D_a, 32'h104);
    step();
    check("drain_validd", {31'd0, ValidD_a}, 32'd0);
    check("drain_instrd", InstrD_a, 32'h00000013);

    // 3: fill under stall, 5th held, then accepted alongside the first pop
    StallD_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 32'h1000 + 32'(i), 32'h300 + 32'(4 * i));
      #1;
      check($sformatf("fill_readyf_%0d", i), {31'd0, ReadyF_a}, 32'd1);
      step();
    end
    drive_a(1'b1, 32'h1004, 32'h310);
    #1;
    check("full_countq", {29'd0, CountQ_a}, 32'd4);
    check("full_readyf", {31'd0, ReadyF_a}, 32'd0);
    check("full_head", InstrD_a, 32'h1000);
    arm = 1'b1;
    #1;
    check("arm_change_head", InstrD_a, 32'h1000);
    arm = 1'b0;
    step();
    check("held_countq", {29'd0, CountQ_a}, 32'd4);
    check("held_head", InstrD_a, 32'h1000);
    StallD_a = 1'b0;
    #1;
    check("full_pop_readyf", {31'd0, ReadyF_a}, 32'd1);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("drain_instr_%0d", j), InstrD_a, 32'h1000 + 32'(j));
      check($sformatf("drain_count_%0d", j), {29'd0, CountQ_a}, 32'(5 - j));
      step();
    end
    check("fill_empty_validd", {31'd0, ValidD_a}, 32'd0);

    // 4: stall holds the head for three cycles
    StallD_a = 1'b1;
    drive_a(1'b1, 32'h2000, 32'h200);
    step();
    drive_a(1'b1, 32'h2001, 32'h204);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_pcd_%0d", k), PCD_a, 32'h200);
      step();
    end
    StallD_a = 1'b0;
    step();
    check("release_pcd", PCD_a, 32'h204);
    check("release_pcplus4d", PCPlus4D_a, 32'h208);
    step();
    check("release_empty", {29'd0, CountQ_a}, 32'd0);

    // 5: flush discards entries and the flush-cycle push
    StallD_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 32'h4000 + 32'(i), 32'h400 + 32'(4 * i));
      step();
    end
    check("preflush_countq", {29'd0, CountQ_a}, 32'd3);
    drive_a(1'b1, 32'hDEAD, 32'h40C);
    FlushD_a = 1'b1;
    step();
    FlushD_a = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    check("flush_countq", {29'd0, CountQ_a}, 32'd0);
    check("flush_validd", {31'd0, ValidD_a}, 32'd0);
    check("flush_pcd", PCD_a, 32'd0);
    drive_a(1'b1, 32'hBEEF, 32'h500);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    check("postflush_countq", {29'd0, CountQ_a}, 32'd1);
    check("postflush_instrd", InstrD_a, 32'hBEEF);
    check("postflush_pcd", PCD_a, 32'h500);
    StallD_a = 1'b0;
    step();
    check("postflush_empty", {29'd0, CountQ_a}, 32'd0);

    // 6: DEPTH=3 streaming push/pop across pointer wrap
    for (int k = 0; k < 10; k++) begin
      ValidF_b   = 1'b1;
      InstrF_b   = 32'hA0 + 32'(k);
      PCF_b      = 32'h600 + 32'(4 * k);
      PCPlus4F_b = 32'h604 + 32'(4 * k);
      step();
      check($sformatf("wrap_instr_%0d", k), InstrD_b, 32'hA0 + 32'(k));
      check($sformatf("wrap_count_%0d", k), {30'd0, CountQ_b}, 32'd1);
    end
    ValidF_b = 1'b0;
    step();
    check("wrap_empty", {30'd0, CountQ_b}, 32'd0);

    // async reset discards entries mid-operation
    StallD_a = 1'b1;
    drive_a(1'b1, 32'h7000, 32'h700);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("async_rst_countq", {29'd0, CountQ_a}, 32'd0);
    check("async_rst_validd", {31'd0, ValidD_a}, 32'd0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
